// File: rtl/logic_func_pkg.sv
`default_nettype none
// ============================================================================
// Package  : logic_func_pkg
// Summary  : Op encodings, sweep FSM state type and the single-lane evaluator
//            shared by the logic function unit and its core.
// Revision : 1.0 - initial release
// ============================================================================
package logic_func_pkg;

    localparam logic [2:0] OP_XOR3        = 3'd0;
    localparam logic [2:0] OP_OR3         = 3'd1;
    localparam logic [2:0] OP_XNOR_AB     = 3'd2;
    localparam logic [2:0] OP_NOR_BC      = 3'd3;
    localparam logic [2:0] OP_NAND_AC_OR_B = 3'd4;
    localparam logic [2:0] OP_AB_OR_C     = 3'd5;
    localparam logic [2:0] OP_AND3        = 3'd6;
    localparam logic [2:0] OP_PASS        = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic eval_op(input logic [2:0] op, input logic a,
                                     input logic b, input logic c);
        logic w_r;
        case (op)
            OP_XOR3:         w_r = a ^ b ^ c;
            OP_OR3:          w_r = a | b | c;
            OP_XNOR_AB:      w_r = ~(a ^ b);
            OP_NOR_BC:       w_r = ~(b | c);
            OP_NAND_AC_OR_B: w_r = ~(a & c) | b;
            OP_AB_OR_C:      w_r = (a & b) | c;
            OP_AND3:         w_r = a & b & c;
            default:         w_r = a;
        endcase
        return w_r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/logic_func_unit_if.sv
`default_nettype none
// ============================================================================
// Interface : logic_func_unit_if
// Summary   : Operand/result stream handshake plus truth-table sweep controls.
// Revision  : 1.0 - initial release
// ============================================================================
interface logic_func_unit_if #(
    parameter int W = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   c;
    logic [2:0]     op;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   y;
    logic           start;
    logic           busy;
    logic           done;
    logic [7:0]     tt;

    modport master (
        output in_valid, a, b, c, op, out_ready, start,
        input  in_ready, out_valid, y, busy, done, tt
    );

    modport slave (
        input  in_valid, a, b, c, op, out_ready, start,
        output in_ready, out_valid, y, busy, done, tt
    );
endinterface
`default_nettype wire

// File: rtl/logic_func_core.sv
`default_nettype none
// ============================================================================
// Module   : logic_func_core
// Summary  : Purely combinational per-lane evaluation of the selected function.
// Revision : 1.0 - initial release
// ============================================================================
module logic_func_core
    import logic_func_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] y
);

    generate
        for (genvar i = 0; i < W; i++) begin : g_lane
            assign y[i] = eval_op(op, a[i], b[i], c[i]);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/logic_func_unit.sv
`default_nettype none
// ============================================================================
// Module   : logic_func_unit
// Summary  : Latency-1 bitwise function stream with optional truth-table sweep
//            (sweep present only when LOGIC_FUNC_UNIT_TT_CAPTURE_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module logic_func_unit
    import logic_func_pkg::*;
#(
    parameter int W = 4
) (
    input  logic              clk,
    input  logic              reset,
    logic_func_unit_if.slave  bus
);

    logic [W-1:0] w_stream_y;
    logic         w_stream_open;
    logic         w_in_ready;
    logic         w_accept;
    logic [W-1:0] r_y;
    logic         r_out_valid;

    logic_func_core #(.W(W)) u_stream_core (
        .op (bus.op),
        .a  (bus.a),
        .b  (bus.b),
        .c  (bus.c),
        .y  (w_stream_y)
    );

`ifdef LOGIC_FUNC_UNIT_TT_CAPTURE_EN
    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_idx;
    logic [2:0] r_op;
    logic [7:0] r_tt;
    logic       w_tt_we;
    logic       w_sweep_bit;

    // The sweep row index doubles as the (a,b,c) operand triple.
    logic_func_core #(.W(1)) u_sweep_core (
        .op (r_op),
        .a  (r_idx[2]),
        .b  (r_idx[1]),
        .c  (r_idx[0]),
        .y  (w_sweep_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_tt_we      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                w_tt_we = 1'b1;
                if (r_idx == 3'd7) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= 3'd0;
            r_op  <= 3'd0;
            r_tt  <= 8'd0;
        end else begin
            if (r_state == ST_IDLE && bus.start) begin
                r_op  <= bus.op;
                r_idx <= 3'd0;
            end
            if (w_tt_we) begin
                r_tt[r_idx] <= w_sweep_bit;
                r_idx       <= r_idx + 3'd1;
            end
        end
    end

    assign w_stream_open = (r_state == ST_IDLE) && !bus.start;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.tt        = r_tt;
`else
    logic w_unused_start;

    assign w_unused_start = bus.start;
    assign w_stream_open  = 1'b1;
    assign bus.busy       = 1'b0;
    assign bus.done       = 1'b0;
    assign bus.tt         = 8'd0;
`endif

    assign w_in_ready = w_stream_open && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    // A new beat replaces a result consumed on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_y         <= '0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_y         <= w_stream_y;
            r_out_valid <= 1'b1;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.y         = r_y;

endmodule
`default_nettype wire

// File: tb/tb_logic_func_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_logic_func_unit
// Summary  : Self-checking bench for logic_func_unit against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_func_unit;

    localparam int W = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic_func_unit_if #(.W(W)) bus ();

    logic_func_unit #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int           vectors     = 0;
    int           miscompares = 0;
    logic         m_ov;
    logic [W-1:0] m_y;

    function automatic logic [W-1:0] ref_f(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [W-1:0] c);
        case (op)
            3'd0:    return a ^ b ^ c;
            3'd1:    return a | b | c;
            3'd2:    return ~(a ^ b);
            3'd3:    return ~(b | c);
            3'd4:    return ~(a & c) | b;
            3'd5:    return (a & b) | c;
            3'd6:    return a & b & c;
            default: return a;
        endcase
    endfunction

    function automatic logic [7:0] ref_tt(input logic [2:0] op);
        logic [7:0]   t;
        logic [W-1:0] v;
        logic [2:0]   row;
        t = 8'd0;
        for (int i = 0; i < 8; i++) begin
            row  = 3'(i);
            v    = ref_f(op, {W{row[2]}}, {W{row[1]}}, {W{row[0]}});
            t[i] = v[0];
        end
        return t;
    endfunction

    task automatic drive(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] ic, input logic [2:0] iop,
                         input logic ordy, input logic st);
        bus.in_valid  = iv;
        bus.a         = ia;
        bus.b         = ib;
        bus.c         = ic;
        bus.op        = iop;
        bus.out_ready = ordy;
        bus.start     = st;
        #1;
    endtask

    // open: the unit is idle and not being asked to start a sweep
    task automatic advance(input logic open);
        logic acc;
        acc = open && bus.in_valid && (!m_ov || bus.out_ready);
        if (acc) begin
            m_y  = ref_f(bus.op, bus.a, bus.b, bus.c);
            m_ov = 1'b1;
        end else if (bus.out_ready) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, W'($urandom), W'($urandom), W'($urandom), 3'($urandom), 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.y !== '0) begin
            miscompares++;
            $display("FAIL reset_out: out_valid=%b y=%h required 0/0", bus.out_valid, bus.y);
        end
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.tt !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_sweep: busy=%b done=%b tt=%h required 0/0/00",
                     bus.busy, bus.done, bus.tt);
        end
        reset = 1'b0;
        m_ov  = 1'b0;
        m_y   = '0;
        drive(1'b0, '0, '0, '0, 3'd0, 1'b1, 1'b0);
        advance(1'b1);
    endtask

    task automatic test_directed();
        logic [W-1:0] exp_y [4];
        logic [2:0]   ops   [4];
        exp_y = '{4'b0000, 4'b1110, 4'b1011, 4'b1110};
        ops   = '{3'd0, 3'd1, 3'd4, 3'd5};
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 4'b1100, 4'b1010, 4'b0110, ops[k], 1'b1, 1'b0);
            vectors++;
            if (bus.in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL directed_ready op=%0d: in_ready=%b required 1", ops[k], bus.in_ready);
            end
            advance(1'b1);
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.y !== exp_y[k]) begin
                miscompares++;
                $display("FAIL directed_y op=%0d: out_valid=%b y=%b required 1 y=%b",
                         ops[k], bus.out_valid, bus.y, exp_y[k]);
            end
        end
        drive(1'b0, '0, '0, '0, 3'd0, 1'b1, 1'b0);
        advance(1'b1);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL directed_drain: out_valid=%b required 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] held;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, W'($urandom), W'($urandom), W'($urandom), 3'($urandom), 1'b1, 1'b0);
            vectors++;
            if (bus.in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_ready beat %0d: in_ready=%b required 1", k, bus.in_ready);
            end
            advance(1'b1);
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.y !== m_y) begin
                miscompares++;
                $display("FAIL b2b_y beat %0d: out_valid=%b y=%h required 1 y=%h",
                         k, bus.out_valid, bus.y, m_y);
            end
        end
        held = m_y;
        // consumer stalls; the offered beat must wait, not vanish
        drive(1'b1, W'($urandom), W'($urandom), W'($urandom), 3'($urandom), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.y !== held) begin
                miscompares++;
                $display("FAIL stall cycle %0d: in_ready=%b out_valid=%b y=%h required 0/1 y=%h",
                         k, bus.in_ready, bus.out_valid, bus.y, held);
            end
            advance(1'b1);
        end
        bus.out_ready = 1'b1;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_release: in_ready=%b required 1", bus.in_ready);
        end
        advance(1'b1);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.y !== m_y) begin
            miscompares++;
            $display("FAIL stall_beat: out_valid=%b y=%h required 1 y=%h", bus.out_valid, bus.y, m_y);
        end
    endtask

    task automatic test_random_stream(input int n, input logic st);
        logic ordy;
        logic exp_rdy;
        for (int k = 0; k < n; k++) begin
            ordy = ($urandom_range(0, 3) != 0);
            drive(1'($urandom), W'($urandom), W'($urandom), W'($urandom), 3'($urandom), ordy, st);
            exp_rdy = !m_ov || ordy;
            vectors++;
            if (bus.in_ready !== exp_rdy) begin
                miscompares++;
                $display("FAIL rand_ready cycle %0d: in_ready=%b required %b", k, bus.in_ready, exp_rdy);
            end
            if (m_ov) begin
                vectors++;
                if (bus.y !== m_y) begin
                    miscompares++;
                    $display("FAIL rand_y cycle %0d: y=%h required %h", k, bus.y, m_y);
                end
            end
            vectors++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.tt !== 8'd0) begin
                miscompares++;
                $display("FAIL idle_sweep cycle %0d: busy=%b done=%b tt=%h required 0/0/00",
                         k, bus.busy, bus.done, bus.tt);
            end
            advance(1'b1);
            vectors++;
            if (bus.out_valid !== m_ov) begin
                miscompares++;
                $display("FAIL rand_valid cycle %0d: out_valid=%b required %b", k, bus.out_valid, m_ov);
            end
        end
    endtask

`ifdef LOGIC_FUNC_UNIT_TT_CAPTURE_EN
    task automatic test_sweep(input logic [2:0] op, input logic [7:0] want, input logic ordy);
        int busy_cnt;
        int done_cnt;
        busy_cnt = 0;
        done_cnt = 0;
        // leave a result pending so its survival across the sweep is visible
        drive(1'b1, W'($urandom), W'($urandom), W'($urandom), 3'($urandom), 1'b1, 1'b0);
        advance(1'b1);
        drive(1'b1, W'($urandom), W'($urandom), W'($urandom), op, ordy, 1'b1);
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL sweep_start_ready op=%0d: in_ready=%b required 0", op, bus.in_ready);
        end
        advance(1'b0);
        for (int it = 0; it < 14; it++) begin
            drive(1'b1, W'($urandom), W'($urandom), W'($urandom), 3'($urandom), ordy, 1'(it < 8));
            if (!bus.busy) break;
            busy_cnt++;
            if (bus.done === 1'b1) done_cnt++;
            advance(1'b0);
        end
        vectors++;
        if (busy_cnt != 9 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL sweep_timing op=%0d: busy cycles=%0d done pulses=%0d required 9/1",
                     op, busy_cnt, done_cnt);
        end
        vectors++;
        if (bus.tt !== want || bus.tt !== ref_tt(op)) begin
            miscompares++;
            $display("FAIL sweep_tt op=%0d: tt=%h required %h", op, bus.tt, want);
        end
        vectors++;
        if (bus.out_valid !== m_ov) begin
            miscompares++;
            $display("FAIL sweep_pending op=%0d: out_valid=%b required %b", op, bus.out_valid, m_ov);
        end
        drive(1'b0, '0, '0, '0, 3'd0, 1'b1, 1'b0);
        advance(1'b1);
    endtask

    task automatic test_start_priority();
        logic [W-1:0] ra, rb, rc;
        logic [2:0]   rop;
        int           cyc;
        ra  = W'($urandom);
        rb  = W'($urandom);
        rc  = W'($urandom);
        rop = 3'($urandom);
        cyc = 0;
        drive(1'b1, ra, rb, rc, rop, 1'b1, 1'b1);
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_ready: in_ready=%b required 0", bus.in_ready);
        end
        advance(1'b0);
        for (int it = 0; it < 14; it++) begin
            drive(1'b1, ra, rb, rc, rop, 1'b1, 1'b0);
            if (!bus.busy) break;
            cyc++;
            vectors++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL prio_busy cycle %0d: in_ready=%b out_valid=%b required 0/0",
                         it, bus.in_ready, bus.out_valid);
            end
            advance(1'b0);
        end
        vectors++;
        if (cyc != 9 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL prio_after_done: busy cycles=%0d in_ready=%b required 9/1", cyc, bus.in_ready);
        end
        advance(1'b1);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.y !== ref_f(rop, ra, rb, rc)) begin
            miscompares++;
            $display("FAIL prio_beat: out_valid=%b y=%h required 1 y=%h",
                     bus.out_valid, bus.y, ref_f(rop, ra, rb, rc));
        end
    endtask

    task automatic test_reset_mid_sweep();
        int done_cnt;
        done_cnt = 0;
        drive(1'b1, W'($urandom), W'($urandom), W'($urandom), 3'($urandom), 1'b0, 1'b0);
        advance(1'b1);
        drive(1'b0, '0, '0, '0, 3'd0, 1'b0, 1'b1);
        advance(1'b0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, '0, '0, '0, 3'd0, 1'b0, 1'b0);
            advance(1'b0);
        end
        vectors++;
        if (bus.busy !== 1'b1 || bus.tt === 8'd0) begin
            miscompares++;
            $display("FAIL midsweep_pre: busy=%b tt=%h required busy 1 and tt nonzero", bus.busy, bus.tt);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_ov  = 1'b0;
        m_y   = '0;
        vectors++;
        if (bus.busy !== 1'b0 || bus.tt !== 8'd0 || bus.done !== 1'b0 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midsweep_reset: busy=%b tt=%h done=%b out_valid=%b required 0/00/0/0",
                     bus.busy, bus.tt, bus.done, bus.out_valid);
        end
        for (int k = 0; k < 12; k++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_cnt++;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (done_cnt != 0) begin
            miscompares++;
            $display("FAIL midsweep_abort: done/busy seen %0d cycles required 0", done_cnt);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        drive(1'b0, '0, '0, '0, 3'd0, 1'b0, 1'b0);
        test_reset();
        test_directed();
        test_back_to_back();
        test_random_stream(200, 1'b0);
`ifdef LOGIC_FUNC_UNIT_TT_CAPTURE_EN
        test_sweep(3'd0, 8'h96, 1'b0);
        test_sweep(3'd5, 8'hEA, 1'b1);
        test_sweep(3'd3, 8'h11, 1'b0);
        test_start_priority();
        test_reset_mid_sweep();
`else
        test_random_stream(40, 1'b1);
        test_directed();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
